// File: rtl/block_emitter.sv
// Serializes BEGIN/END/OTHER/SPACE commands as ASCII words plus a trailing space, tracking nesting depth.
// Define BLOCK_EMITTER_UPPER_EN to emit uppercase letters instead of lowercase.
module block_emitter #(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  output logic               out_valid,
  output logic [7:0]         out_char,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  typedef enum logic {IDLE, EMIT} state_e;
  typedef enum logic [1:0] {
    CMD_BEGIN = 2'd0,
    CMD_END   = 2'd1,
    CMD_OTHER = 2'd2,
    CMD_SPACE = 2'd3
  } cmd_e;

`ifdef BLOCK_EMITTER_UPPER_EN
  localparam logic [7:0] CASE_OFS = 8'h20;
`else
  localparam logic [7:0] CASE_OFS = 8'h00;
`endif

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;

  function automatic logic [2:0] last_idx(input cmd_e c);
    logic [2:0] l;
    l = 3'd0;
    unique case (c)
      CMD_BEGIN: l = 3'd5;
      CMD_END:   l = 3'd3;
      CMD_OTHER: l = 3'd1;
      CMD_SPACE: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] word_char(input cmd_e c, input logic [2:0] i);
    logic [7:0] ch;
    ch = 8'h20;
    unique case (c)
      CMD_BEGIN:
        case (i)
          3'd0:    ch = 8'h62;
          3'd1:    ch = 8'h65;
          3'd2:    ch = 8'h67;
          3'd3:    ch = 8'h69;
          3'd4:    ch = 8'h6E;
          default: ch = 8'h20;
        endcase
      CMD_END:
        case (i)
          3'd0:    ch = 8'h65;
          3'd1:    ch = 8'h6E;
          3'd2:    ch = 8'h64;
          default: ch = 8'h20;
        endcase
      CMD_OTHER: ch = (i == 3'd0) ? 8'h77 : 8'h20;
      CMD_SPACE: ch = 8'h20;
    endcase
    // Letters only; the trailing space is never case-shifted.
    if (ch != 8'h20) ch = ch - CASE_OFS;
    return ch;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_SPACE;
      idx_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    depth_d   = depth_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h20;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d   = cmd_e'(cmd);
          idx_d   = '0;
          state_d = EMIT;
          unique case (cmd_e'(cmd))
            CMD_BEGIN: if (depth_q != DEPTH_MAX) depth_d = depth_q + DEPTH_W'(1);
            CMD_END: begin
              if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
              else               err_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_char  = word_char(cmd_q, idx_q);
        if (idx_q == last_idx(cmd_q)) state_d = IDLE;
        else                          idx_d   = idx_q + 3'd1;
      end
    endcase
  end

  assign depth    = depth_q;
  assign err      = err_q;
  assign balanced = (depth_q == '0) && !err_q;

endmodule

// File: tb/tb_block_emitter.sv
// Scoreboard bench for block_emitter: two instances (DEPTH_W 8 and 2) share one stimulus stream.
module tb_block_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;

  logic       r0, v0, e0, b0, r1, v1, e1, b1;
  logic [7:0] c0, c1, d0;
  logic [1:0] d1;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int md[2];
  bit me[2];
  int dmax[2] = '{255, 3};
  int busy = 0;

  always #5 clk = ~clk;

  block_emitter #(.DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(r0), .out_valid(v0), .out_char(c0),
    .depth(d0), .err(e0), .balanced(b0)
  );

  block_emitter #(.DEPTH_W(2)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(r1), .out_valid(v1), .out_char(c1),
    .depth(d1), .err(e1), .balanced(b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic string word_of(input logic [1:0] c);
`ifdef BLOCK_EMITTER_UPPER_EN
    case (c)
      2'd0: return "BEGIN ";
      2'd1: return "END ";
      2'd2: return "W ";
      default: return " ";
    endcase
`else
    case (c)
      2'd0: return "begin ";
      2'd1: return "end ";
      2'd2: return "w ";
      default: return " ";
    endcase
`endif
  endfunction

  task automatic model_accept(input logic [1:0] c);
    string s;
    s = word_of(c);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    busy = s.len();
    for (int k = 0; k < 2; k++) begin
      if (c == 2'd0 && md[k] < dmax[k]) md[k]++;
      else if (c == 2'd1) begin
        if (md[k] > 0) md[k]--;
        else me[k] = 1'b1;
      end
    end
  endtask

  task automatic check_cycle();
    chk("cmd_ready8", r0, busy == 0);
    chk("cmd_ready2", r1, busy == 0);
    chk("out_valid8", v0, busy > 0);
    chk("out_valid2", v1, busy > 0);
    if (busy == 0) begin
      chk("idle_char8", c0, 8'h20);
      chk("idle_char2", c1, 8'h20);
    end
    chk("depth8", d0, md[0]);
    chk("depth2", d1, md[1]);
    chk("err8", e0, me[0]);
    chk("err2", e1, me[1]);
    chk("balanced8", b0, md[0] == 0 && !me[0]);
    chk("balanced2", b1, md[1] == 0 && !me[1]);
  endtask

  task automatic step(input bit v, input logic [1:0] c);
    bit rdy;
    @(negedge clk);
    check_cycle();
    rdy = (busy == 0);
    if (busy > 0) busy--;
    cmd_valid = v;
    cmd = c;
    if (rdy && v) model_accept(c);
  endtask

  task automatic send(input logic [1:0] c);
    step(1'b1, c);
    while (busy > 0) step(1'b0, 2'($urandom_range(0, 3)));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rst_ready8", r0, 1);  chk("rst_ready2", r1, 1);
    chk("rst_valid8", v0, 0);  chk("rst_valid2", v1, 0);
    chk("rst_char8", c0, 8'h20); chk("rst_char2", c1, 8'h20);
    chk("rst_depth8", d0, 0);  chk("rst_depth2", d1, 0);
    chk("rst_err8", e0, 0);    chk("rst_err2", e1, 0);
    chk("rst_bal8", b0, 1);    chk("rst_bal2", b1, 1);
    exp_q.delete();
    busy = 0;
    md = '{0, 0};
    me = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  // Byte-stream monitor: every presented byte must be the next scoreboard entry.
  always @(negedge clk) begin
    if (reset && (v0 || v1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {v0, v1}, 2'b00);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("byte8", c0, e);
        chk("byte2", c1, e);
      end
    end
  end

  initial begin
    md = '{0, 0};
    me = '{1'b0, 1'b0};
    do_reset();
    repeat (5) step(1'b0, 2'd0);

    // BEGIN with END held through the emission: END is taken exactly one idle cycle later.
    step(1'b1, 2'd0);
    repeat (7) step(1'b1, 2'd1);
    repeat (5) step(1'b0, 2'd0);
    chk("begin_end_balanced", b0, 1);

    do_reset();
    send(2'd1);
    send(2'd0);
    send(2'd1);
    step(1'b0, 2'd0);
    chk("err_sticky", e0, 1);
    chk("err_depth0", d0, 0);
    chk("err_unbalanced", b0, 0);

    do_reset();
    repeat (20) step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    chk("held_begin_depth", d0, 3);
    while (busy > 0) step(1'b0, 2'd0);

    do_reset();
    repeat (5) send(2'd0);
    step(1'b0, 2'd0);
    chk("sat2_depth", d1, 3);
    repeat (3) send(2'd1);
    step(1'b0, 2'd0);
    chk("sat2_unwind", d1, 0);
    chk("sat2_err", e1, 0);

    // Reset lands while the third BEGIN byte is on the output.
    do_reset();
    step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    do_reset();
    send(2'd2);
    step(1'b0, 2'd0);

    do_reset();
    repeat (260) send(2'd0);
    step(1'b0, 2'd0);
    chk("sat8_depth", d0, 255);

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)));
    end
    while (busy > 0) step(1'b0, 2'd0);
    repeat (2) step(1'b0, 2'd0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
